// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit: opcodes,
// funct codes, ALU operation codes, FSM state codes and the internal control
// word. Imported by the control unit, its ALU decoder and the bench.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SHL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_EQ  = 6'b101010;

  // ULA operation encoding
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_SHR = 4'd6;
  localparam logic [3:0] ALU_MUL = 4'd7;
  localparam logic [3:0] ALU_EQ  = 4'd8;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // Ungated control word decoded from the current state
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    aluop_t     aluop;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle control unit and the datapath.
//   enable, opcode, funct, alu_zero, mem_ready : datapath -> control
//   pc_en .. alu_control, state, illegal_op    : control -> datapath
// master = control unit, slave = datapath.
interface multicycle_control_if #(
  parameter int ALU_CTRL_W = 4
);
  logic                  enable;
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic                  alu_zero;
  logic                  mem_ready;

  logic                  pc_en;
  logic [1:0]            pc_source;
  logic                  iord;
  logic                  mem_read;
  logic                  mem_write;
  logic                  ir_write;
  logic                  reg_dst;
  logic                  mem_to_reg;
  logic                  reg_write;
  logic                  alu_src_a;
  logic [1:0]            alu_src_b;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [3:0]            state;
  logic                  illegal_op;

  modport master (
    input  enable, opcode, funct, alu_zero, mem_ready,
    output pc_en, pc_source, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control, state,
           illegal_op
  );

  modport slave (
    output enable, opcode, funct, alu_zero, mem_ready,
    input  pc_en, pc_source, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control, state,
           illegal_op
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: maps (aluop, funct) to the ULA operation code.
//   aluop       in  2-bit selector: add, sub, or decode funct
//   funct       in  IR[5:0]
//   alu_control out ULA operation, zero-extended to ALU_CTRL_W
// Unknown funct falls back to add; there is no trap for it.
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  aluop_t                aluop,
  input  logic [5:0]            funct,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic [3:0] code;

  always_comb begin
    code = ALU_ADD;
    case (aluop)
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  code = ALU_ADD;
          FN_SUB:  code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_XOR:  code = ALU_XOR;
          FN_SHL:  code = ALU_SHL;
          FN_SRL:  code = ALU_SHR;
          FN_MUL:  code = ALU_MUL;
          FN_EQ:   code = ALU_EQ;
          default: code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit for the MIPS-subset datapath (R, lw, sw, beq,
// addi, j). One instruction takes 3-5 cycles through shared memory and ALU.
//   clock, reset  : rising-edge clock, async active-high reset
//   bus (master)  : enable/opcode/funct/alu_zero/mem_ready in; datapath
//                   strobes, mux selects, alu_control, state, illegal_op out
// State register is the only flop. While reset is high every output reads 0,
// so an aborted instruction can never issue a write after reset rises.
// enable=0 freezes the state and kills every strobe; mux selects keep their
// decoded values.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_WAIT_EN = 1,
  parameter int ENABLE_JUMP = 1
) (
  input  logic                clock,
  input  logic                reset,
  multicycle_control_if.master bus
);

  state_t                state_q;
  state_t                state_d;
  ctrl_t                 ctrl;
  logic                  mem_rdy;
  logic                  op_legal;
  logic                  live;
  logic [ALU_CTRL_W-1:0] alu_dec;

  assign mem_rdy = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;

  always_comb begin
    op_legal = 1'b0;
    case (bus.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: op_legal = 1'b1;
      OP_J:    op_legal = (ENABLE_JUMP != 0);
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.enable) begin
      case (state_q)
        S_FETCH:  if (mem_rdy) state_d = S_DECODE;
        S_DECODE: begin
          if (!op_legal) state_d = S_FETCH;
          else begin
            case (bus.opcode)
              OP_LW, OP_SW: state_d = S_MEMADR;
              OP_RTYPE:     state_d = S_EXEC;
              OP_BEQ:       state_d = S_BRANCH;
              OP_ADDI:      state_d = S_ADDIEX;
              OP_J:         state_d = S_JUMP;
              default:      state_d = S_FETCH;
            endcase
          end
        end
        S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
        S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
        S_EXEC:   state_d = S_ALUWB;
        S_ADDIEX: state_d = S_ADDIWB;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl       = '0;
    ctrl.aluop = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        // PC and IR only update on the cycle the memory delivers the word
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_rdy;
        ctrl.pc_write  = mem_rdy;
        ctrl.alu_src_b = 2'b01;
      end
      S_DECODE: ctrl.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.aluop         = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  multicycle_control_alu_decoder #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_dec (
    .aluop       (ctrl.aluop),
    .funct       (bus.funct),
    .alu_control (alu_dec)
  );

  assign live = bus.enable & ~reset;

  assign bus.pc_en       = live & (ctrl.pc_write | (ctrl.pc_write_cond & bus.alu_zero));
  assign bus.mem_read    = live & ctrl.mem_read;
  assign bus.mem_write   = live & ctrl.mem_write;
  assign bus.ir_write    = live & ctrl.ir_write;
  assign bus.reg_write   = live & ctrl.reg_write;
  assign bus.illegal_op  = live & (state_q == S_DECODE) & ~op_legal;

  assign bus.pc_source   = reset ? 2'b00 : ctrl.pc_source;
  assign bus.iord        = ~reset & ctrl.iord;
  assign bus.reg_dst     = ~reset & ctrl.reg_dst;
  assign bus.mem_to_reg  = ~reset & ctrl.mem_to_reg;
  assign bus.alu_src_a   = ~reset & ctrl.alu_src_a;
  assign bus.alu_src_b   = reset ? 2'b00 : ctrl.alu_src_b;
  assign bus.alu_control = reset ? '0 : alu_dec;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a directed vector table, hand-written reset
// sequences, and a randomized run against an instruction-level model.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  // Per-state control values, one record per state code
  typedef struct packed {
    logic       pcw;
    logic       pcc;
    logic [1:0] psrc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] kind;   // 0 add, 1 sub, 2 from funct
  } rec_t;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        zero;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [15:0] exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multicycle_control_if #(.ALU_CTRL_W(4)) bus ();

  multicycle_control #(
    .ALU_CTRL_W  (4),
    .MEM_WAIT_EN (1),
    .ENABLE_JUMP (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  rec_t tab[12];
  vec_t vecs[$];
  int   path[$];
  int   idx;
  logic [5:0] cur_opc;
  logic [5:0] cur_fn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic add_vec(input logic en, input logic rdy, input logic zero,
                         input logic [5:0] opc, input logic [5:0] fn,
                         input logic [3:0] st, input logic [6:0] flags,
                         input logic [3:0] alu, input logic ill);
    vec_t v;
    v.en = en; v.rdy = rdy; v.zero = zero; v.opc = opc; v.fn = fn;
    v.exp = {st, flags, alu, ill};
    vecs.push_back(v);
  endtask

  // {state, pc_en, mem_read, mem_write, ir_write, reg_write, mem_to_reg, reg_dst, alu_control, illegal_op}
  function automatic logic [15:0] short_outs();
    return {bus.state, bus.pc_en, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.reg_write, bus.mem_to_reg, bus.reg_dst, bus.alu_control, bus.illegal_op};
  endfunction

  function automatic logic [21:0] full_outs();
    return {bus.pc_en, bus.pc_source, bus.iord, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
            bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.state, bus.illegal_op};
  endfunction

  function automatic logic [3:0] funct_code(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'd0;
      6'b100010: return 4'd1;
      6'b100100: return 4'd2;
      6'b100101: return 4'd3;
      6'b100110: return 4'd4;
      6'b000000: return 4'd5;
      6'b000010: return 4'd6;
      6'b011000: return 4'd7;
      6'b101010: return 4'd8;
      default:   return 4'd0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] opc);
    return (opc == 6'b000000) || (opc == 6'b100011) || (opc == 6'b101011) ||
           (opc == 6'b000100) || (opc == 6'b001000) || (opc == 6'b000010);
  endfunction

  function automatic logic [21:0] model_outs(input int st, input logic en, input logic rdy,
                                             input logic zero, input logic [5:0] opc,
                                             input logic [5:0] fn);
    rec_t       r;
    logic       done;
    logic       pc_en;
    logic [3:0] alu;
    logic       ill;
    r     = tab[st];
    done  = !(st == 0 || st == 3 || st == 5) || rdy;
    pc_en = en & ((r.pcw & done) | (r.pcc & zero));
    alu   = (r.kind == 2'd0) ? 4'd0 : (r.kind == 2'd1) ? 4'd1 : funct_code(fn);
    ill   = en && (st == 1) && !is_legal(opc);
    return {pc_en, r.psrc, r.iord, en & r.mrd, en & r.mwr, en & r.irw & done,
            r.rdst, r.m2r, en & r.rw, r.sa, r.sb, alu, 4'(st), ill};
  endfunction

  // Choose the next instruction and the state path it must walk
  task automatic pick_instr();
    logic [5:0] fl[9];
    logic [5:0] il[5];
    int k;
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
           6'b000000, 6'b000010, 6'b011000, 6'b101010};
    il = '{6'b111111, 6'b000001, 6'b001100, 6'b110000, 6'b100100};
    k = $urandom_range(0, 6);
    cur_fn = 6'($urandom_range(0, 63));
    case (k)
      0: begin cur_opc = 6'b100011; path = '{0, 1, 2, 3, 4}; end
      1: begin cur_opc = 6'b101011; path = '{0, 1, 2, 5}; end
      2: begin
        cur_opc = 6'b000000; path = '{0, 1, 6, 7};
        if ($urandom_range(0, 3) != 0) cur_fn = fl[$urandom_range(0, 8)];
      end
      3: begin cur_opc = 6'b000100; path = '{0, 1, 8}; end
      4: begin cur_opc = 6'b001000; path = '{0, 1, 9, 10}; end
      5: begin cur_opc = 6'b000010; path = '{0, 1, 11}; end
      default: begin cur_opc = il[$urandom_range(0, 4)]; path = '{0, 1}; end
    endcase
    idx = 0;
  endtask

  initial begin
    tab[0]  = 16'b1_0_00_0_1_0_1_0_0_0_0_01_00;
    tab[1]  = 16'b0_0_00_0_0_0_0_0_0_0_0_11_00;
    tab[2]  = 16'b0_0_00_0_0_0_0_0_0_0_1_10_00;
    tab[3]  = 16'b0_0_00_1_1_0_0_0_0_0_0_00_00;
    tab[4]  = 16'b0_0_00_0_0_0_0_0_1_1_0_00_00;
    tab[5]  = 16'b0_0_00_1_0_1_0_0_0_0_0_00_00;
    tab[6]  = 16'b0_0_00_0_0_0_0_0_0_0_1_00_10;
    tab[7]  = 16'b0_0_00_0_0_0_0_1_0_1_0_00_00;
    tab[8]  = 16'b0_1_01_0_0_0_0_0_0_0_1_00_01;
    tab[9]  = 16'b0_0_00_0_0_0_0_0_0_0_1_10_00;
    tab[10] = 16'b0_0_00_0_0_0_0_0_0_1_0_00_00;
    tab[11] = 16'b1_0_10_0_0_0_0_0_0_0_0_00_00;

    // flags = {pc_en, mem_read, mem_write, ir_write, reg_write, mem_to_reg, reg_dst}
    // lw
    add_vec(1, 1, 0, 6'b100011, 6'b000000, 4'd0, 7'b1101000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b100011, 6'b000000, 4'd1, 7'b0000000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b100011, 6'b000000, 4'd2, 7'b0000000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b100011, 6'b000000, 4'd3, 7'b0100000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b100011, 6'b000000, 4'd4, 7'b0000110, 4'd0, 0);
    // R-type sub
    add_vec(1, 1, 0, 6'b000000, 6'b100010, 4'd0, 7'b1101000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b000000, 6'b100010, 4'd1, 7'b0000000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b000000, 6'b100010, 4'd6, 7'b0000000, 4'd1, 0);
    add_vec(1, 1, 0, 6'b000000, 6'b100010, 4'd7, 7'b0000101, 4'd0, 0);
    // beq taken, then not taken
    add_vec(1, 1, 1, 6'b000100, 6'b000000, 4'd0, 7'b1101000, 4'd0, 0);
    add_vec(1, 1, 1, 6'b000100, 6'b000000, 4'd1, 7'b0000000, 4'd0, 0);
    add_vec(1, 1, 1, 6'b000100, 6'b000000, 4'd8, 7'b1000000, 4'd1, 0);
    add_vec(1, 1, 0, 6'b000100, 6'b000000, 4'd0, 7'b1101000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b000100, 6'b000000, 4'd1, 7'b0000000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b000100, 6'b000000, 4'd8, 7'b0000000, 4'd1, 0);
    // fetch wait states, then R-type with a stall in ALUWB
    add_vec(1, 0, 0, 6'b000000, 6'b100000, 4'd0, 7'b0100000, 4'd0, 0);
    add_vec(1, 0, 0, 6'b000000, 6'b100000, 4'd0, 7'b0100000, 4'd0, 0);
    add_vec(1, 0, 0, 6'b000000, 6'b100000, 4'd0, 7'b0100000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b000000, 6'b100000, 4'd0, 7'b1101000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b000000, 6'b100000, 4'd1, 7'b0000000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b000000, 6'b100000, 4'd6, 7'b0000000, 4'd0, 0);
    add_vec(0, 1, 0, 6'b000000, 6'b100000, 4'd7, 7'b0000001, 4'd0, 0);
    add_vec(1, 1, 0, 6'b000000, 6'b100000, 4'd7, 7'b0000101, 4'd0, 0);
    // illegal opcode
    add_vec(1, 1, 0, 6'b111111, 6'b000000, 4'd0, 7'b1101000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b111111, 6'b000000, 4'd1, 7'b0000000, 4'd0, 1);
    // sw with one write wait state
    add_vec(1, 1, 0, 6'b101011, 6'b000000, 4'd0, 7'b1101000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b101011, 6'b000000, 4'd1, 7'b0000000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b101011, 6'b000000, 4'd2, 7'b0000000, 4'd0, 0);
    add_vec(1, 0, 0, 6'b101011, 6'b000000, 4'd5, 7'b0010000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b101011, 6'b000000, 4'd5, 7'b0010000, 4'd0, 0);
    // addi
    add_vec(1, 1, 0, 6'b001000, 6'b000000, 4'd0, 7'b1101000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b001000, 6'b000000, 4'd1, 7'b0000000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b001000, 6'b000000, 4'd9, 7'b0000000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b001000, 6'b000000, 4'd10, 7'b0000100, 4'd0, 0);
    // j
    add_vec(1, 1, 0, 6'b000010, 6'b000000, 4'd0, 7'b1101000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b000010, 6'b000000, 4'd1, 7'b0000000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b000010, 6'b000000, 4'd11, 7'b1000000, 4'd0, 0);
    add_vec(1, 1, 0, 6'b000010, 6'b000000, 4'd0, 7'b1101000, 4'd0, 0);

    reset         = 1'b1;
    bus.enable    = 1'b1;
    bus.mem_ready = 1'b0;
    bus.alu_zero  = 1'b0;
    bus.opcode    = 6'b100011;
    bus.funct     = 6'b000000;
    repeat (2) @(negedge clock);
    #1 check("reset_zero", 32'(full_outs()), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      bus.enable    = vecs[i].en;
      bus.mem_ready = vecs[i].rdy;
      bus.alu_zero  = vecs[i].zero;
      bus.opcode    = vecs[i].opc;
      bus.funct     = vecs[i].fn;
      #1 check($sformatf("vec%0d", i), 32'(short_outs()), 32'(vecs[i].exp));
    end

    // Reset in the middle of a lw memory read
    @(negedge clock);
    reset = 1'b1;
    #1 reset = 1'b0;
    bus.enable    = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'b100011;
    repeat (3) @(posedge clock);
    @(negedge clock);
    bus.mem_ready = 1'b0;
    #1 check("memrd_before_reset", 32'({bus.state, bus.mem_read}), 32'({4'd3, 1'b1}));
    #2 reset = 1'b1;
    #1 check("reset_in_memrd", 32'(full_outs()), 32'd0);
    @(posedge clock);
    #1 bus.mem_ready = 1'b1;
    #1 check("reset_held", 32'(full_outs()), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 check("fetch_after_reset", 32'({bus.state, bus.mem_read, bus.ir_write}), 32'({4'd0, 1'b1, 1'b1}));
    bus.enable = 1'b0;

    // Randomized run against the instruction-level model
    pick_instr();
    for (int c = 0; c < 3000; c++) begin
      logic en;
      logic rdy;
      logic zero;
      int   st;
      @(negedge clock);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        #1 check("rand_reset", 32'(full_outs()), 32'd0);
        reset = 1'b0;
        pick_instr();
      end
      en   = ($urandom_range(0, 7) != 0);
      rdy  = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom_range(0, 1));
      bus.enable    = en;
      bus.mem_ready = rdy;
      bus.alu_zero  = zero;
      bus.opcode    = cur_opc;
      bus.funct     = cur_fn;
      st = path[idx];
      #1 check($sformatf("rand%0d_st%0d", c, st), 32'(full_outs()),
               32'(model_outs(st, en, rdy, zero, cur_opc, cur_fn)));
      if (en && (!(st == 0 || st == 3 || st == 5) || rdy)) begin
        idx++;
        if (idx == path.size()) pick_instr();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
